// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path: FSM states,
// frame configuration latched at frame load, and default bit divisors.
package uart_pkg;

  localparam int DATA_W       = 8;
  localparam int BAUD_W       = 13;
  localparam int DIV_SLOW_DEF = 5208;
  localparam int DIV_FAST_DEF = 434;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  typedef struct packed {
    logic parity_en;
    logic eight_bit;
    logic fast;
  } frame_cfg_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous transmit FIFO; full/empty are registered from the next-state count.
module tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic [CW-1:0]     count_n;
  logic              push_ok;
  logic              pop_ok;

  // A pop in the same cycle frees the slot, so a push while full is still accepted.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  always_comb begin
    count_n = count;
    case ({push_ok, pop_ok})
      2'b10:   count_n = count + CW'(1);
      2'b01:   count_n = count - CW'(1);
      default: count_n = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_n;
      full  <= (count_n == CW'(DEPTH));
      empty <= (count_n == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= data_in;
  end

  assign data_out = mem[rd_ptr];

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: FIFO-buffered bytes serialised as start, 7/8 data bits
// LSB-first, optional even parity and one stop bit, with switch-selected baud.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int DIV_SLOW   = (CLK_FREQ == 50000000) ? DIV_SLOW_DEF : CLK_FREQ / 9600,
  parameter int DIV_FAST   = (CLK_FREQ == 50000000) ? DIV_FAST_DEF : CLK_FREQ / 115200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              write_enable,
  input  logic              SW0,
  input  logic              SW1,
  input  logic              SW2,
  output logic              Tx,
  output logic              busy,
  output logic              tx_done,
  output logic              full,
  output logic              empty,
  output logic              overrun_err,
  output tx_state_e         tx_state
);

  // Handshake: write_enable is a push with no ready; a byte offered while full
  // (and not freed by a same-cycle pop) is dropped and flagged on overrun_err.

  localparam logic [BAUD_W-1:0] SLOW_M1 = BAUD_W'(DIV_SLOW - 1);
  localparam logic [BAUD_W-1:0] FAST_M1 = BAUD_W'(DIV_FAST - 1);

  tx_state_e         state, state_n;
  logic [BAUD_W-1:0] cnt, cnt_n;
  logic [DATA_W-1:0] shift, shift_n;
  logic [2:0]        idx, idx_n;
  logic              par, par_n;
  frame_cfg_t        cfg, cfg_n;
  logic              pop;
  logic              load;
  logic              tx_n;
  logic              done_n;
  logic [DATA_W-1:0] fifo_dout;
  logic [BAUD_W-1:0] div_m1;
  logic              bit_end;
  logic              last_bit;

  tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (write_enable),
    .pop      (pop),
    .data_in  (data_in),
    .data_out (fifo_dout),
    .full     (full),
    .empty    (empty)
  );

  assign div_m1   = cfg.fast ? FAST_M1 : SLOW_M1;
  assign bit_end  = (cnt == div_m1);
  assign last_bit = (idx == (cfg.eight_bit ? 3'd7 : 3'd6));
  assign tx_state = state;

  // Tx is registered from the value belonging to the next state, so the line
  // changes on the same edge the FSM moves.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    shift_n = shift;
    idx_n   = idx;
    par_n   = par;
    cfg_n   = cfg;
    tx_n    = Tx;
    load    = 1'b0;
    pop     = 1'b0;
    done_n  = 1'b0;

    case (state)
      IDLE: begin
        tx_n = 1'b1;
        if (!empty) load = 1'b1;
      end
      START: begin
        if (bit_end) begin
          cnt_n   = '0;
          idx_n   = '0;
          state_n = DATA;
          tx_n    = shift[0];
        end else begin
          cnt_n = cnt + BAUD_W'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_n   = '0;
          par_n   = par ^ shift[0];
          shift_n = shift >> 1;
          if (last_bit) begin
            state_n = cfg.parity_en ? PARITY : STOP;
            tx_n    = cfg.parity_en ? (par ^ shift[0]) : 1'b1;
          end else begin
            idx_n = idx + 3'd1;
            tx_n  = shift[1];
          end
        end else begin
          cnt_n = cnt + BAUD_W'(1);
        end
      end
      PARITY: begin
        if (bit_end) begin
          cnt_n   = '0;
          state_n = STOP;
          tx_n    = 1'b1;
        end else begin
          cnt_n = cnt + BAUD_W'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          cnt_n   = '0;
          state_n = IDLE;
          tx_n    = 1'b1;
          if (!empty) load = 1'b1;
        end else begin
          cnt_n = cnt + BAUD_W'(1);
        end
      end
      default: begin
        state_n = IDLE;
        tx_n    = 1'b1;
      end
    endcase

    // Frame load is shared by IDLE and the back-to-back path out of STOP.
    if (load) begin
      pop     = 1'b1;
      shift_n = fifo_dout;
      cfg_n   = '{parity_en: SW0, eight_bit: SW1, fast: SW2};
      cnt_n   = '0;
      idx_n   = '0;
      par_n   = 1'b0;
      state_n = START;
      tx_n    = 1'b0;
    end

    done_n = (state_n == STOP) && (cnt_n == div_m1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      shift       <= '0;
      idx         <= '0;
      par         <= 1'b0;
      cfg         <= '0;
      Tx          <= 1'b1;
      busy        <= 1'b0;
      tx_done     <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      shift       <= shift_n;
      idx         <= idx_n;
      par         <= par_n;
      cfg         <= cfg_n;
      Tx          <= tx_n;
      busy        <= (state_n != IDLE);
      tx_done     <= done_n;
      overrun_err <= write_enable && full && !pop;
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed and randomized bench for uart_transmitter, checked against a
// frame-level bit-list model of the serial line.
module tb_uart_transmitter;
  import uart_pkg::*;

  localparam int DS    = 24;
  localparam int DF    = 10;
  localparam int BOUND = 20 * DS;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  data_in;
  logic        write_enable;
  logic        SW0, SW1, SW2;
  logic        Tx, busy, tx_done, full, empty, overrun_err;
  tx_state_e   tx_state;

  int checks = 0;
  int errors = 0;

  uart_transmitter #(
    .CLK_FREQ   (50000000),
    .DIV_SLOW   (DS),
    .DIV_FAST   (DF),
    .FIFO_DEPTH (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .data_in      (data_in),
    .write_enable (write_enable),
    .SW0          (SW0),
    .SW1          (SW1),
    .SW2          (SW2),
    .Tx           (Tx),
    .busy         (busy),
    .tx_done      (tx_done),
    .full         (full),
    .empty        (empty),
    .overrun_err  (overrun_err),
    .tx_state     (tx_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // drivers (called at a negedge, return at a later negedge)
  task automatic set_sw(input logic [2:0] sw);
    {SW2, SW1, SW0} = sw;
  endtask

  task automatic write_byte(input logic [7:0] b);
    data_in      = b;
    write_enable = 1'b1;
    @(negedge clk);
    write_enable = 1'b0;
  endtask

  // Reference model: the frame as a list of line levels, each held for one bit time.
  task automatic check_frame(input logic [7:0] b, input logic [2:0] sw, output int waited);
    logic bits [$];
    int   nb, div, bad;
    logic [7:0] mask;
    bits = {};
    nb   = sw[1] ? 8 : 7;
    mask = sw[1] ? 8'hFF : 8'h7F;
    div  = sw[2] ? DF : DS;
    bits.push_back(1'b0);
    for (int i = 0; i < nb; i++) bits.push_back(b[i]);
    if (sw[0]) bits.push_back(^(b & mask));
    bits.push_back(1'b1);

    waited = 0;
    while (Tx !== 1'b0 && waited < BOUND) begin
      @(negedge clk);
      waited++;
    end
    check("start_seen", (waited < BOUND), 1);
    if (waited >= BOUND) return;

    for (int i = 0; i < bits.size(); i++) begin
      bad = 0;
      for (int c = 0; c < div; c++) begin
        if (Tx !== bits[i] || busy !== 1'b1) bad++;
        if (tx_done !== ((i == bits.size() - 1) && (c == div - 1))) bad++;
        @(negedge clk);
      end
      check($sformatf("frame_%02h_bit%0d", b, i), bad, 0);
    end
  endtask

  task automatic check_quiet(input string tag, input int n);
    int bad;
    bad = 0;
    for (int c = 0; c < n; c++) begin
      if (Tx !== 1'b1 || busy !== 1'b0 || tx_done !== 1'b0) bad++;
      @(negedge clk);
    end
    check(tag, bad, 0);
  endtask

  initial begin
    int w;
    logic [7:0] rb;
    logic [2:0] rsw;

    rst = 1'b1;
    data_in = '0;
    write_enable = 1'b0;
    set_sw(3'b000);
    repeat (3) @(negedge clk);
    check("rst_tx", Tx, 1);
    check("rst_busy", busy, 0);
    check("rst_done", tx_done, 0);
    check("rst_full", full, 0);
    check("rst_empty", empty, 1);
    check("rst_overrun", overrun_err, 0);
    rst = 1'b0;
    @(negedge clk);
    check_quiet("idle_after_reset", 4);

    // 7N at slow rate
    set_sw(3'b000);
    write_byte(8'h41);
    check_frame(8'h41, 3'b000, w);
    check("latency_7n", w, 1);
    check("busy_off_7n", busy, 0);

    // 8N fast
    set_sw(3'b110);
    write_byte(8'h55);
    check_frame(8'h55, 3'b110, w);
    check("latency_8n", w, 1);

    // 8E fast, odd and even data weight
    set_sw(3'b111);
    write_byte(8'h07);
    check_frame(8'h07, 3'b111, w);
    write_byte(8'h03);
    check_frame(8'h03, 3'b111, w);

    // 7E fast, bit 7 must not be sent
    set_sw(3'b101);
    write_byte(8'hFF);
    check_frame(8'hFF, 3'b101, w);
    check("busy_off_7e", busy, 0);

    // random single frames
    for (int k = 0; k < 8; k++) begin
      rb  = 8'($urandom_range(0, 255));
      rsw = 3'($urandom_range(0, 7));
      set_sw(rsw);
      write_byte(rb);
      check_frame(rb, rsw, w);
      check("latency_rand", w, 1);
    end

    // FIFO fill, overrun and back-to-back frames
    set_sw(3'b110);
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          data_in      = 8'(i);
          write_enable = 1'b1;
          @(negedge clk);
          if (i == 8) begin
            check("full_after_9th", full, 1);
            check("no_early_overrun", overrun_err, 0);
          end
          if (i == 9) check("overrun_pulse", overrun_err, 1);
        end
        write_enable = 1'b0;
        @(negedge clk);
        check("overrun_once", overrun_err, 0);
        check("full_held", full, 1);
      end
      begin
        for (int f = 0; f < 9; f++) begin
          if (f == 8) check("empty_before_last", empty, 1);
          check_frame(8'(f), 3'b110, w);
          if (f > 0) check("no_gap", w, 0);
        end
      end
    join
    check("empty_after_burst", empty, 1);
    check_quiet("dropped_byte_not_sent", 3 * DF);

    // reset in the middle of a frame clears the FIFO too
    set_sw(3'b110);
    write_byte(8'h00);
    write_byte(8'h5A);
    w = 0;
    while (Tx !== 1'b0 && w < BOUND) begin
      @(negedge clk);
      w++;
    end
    repeat (DF + 3) @(negedge clk);
    check("in_data_before_rst", tx_state, DATA);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_tx", Tx, 1);
    check("midrst_busy", busy, 0);
    check("midrst_empty", empty, 1);
    check("midrst_full", full, 0);
    rst = 1'b0;
    check_quiet("quiet_after_midrst", 3 * DS);

    // SW2 change mid-frame only affects the next frame
    set_sw(3'b110);
    write_byte(8'hA5);
    fork
      check_frame(8'hA5, 3'b110, w);
      begin
        repeat (15) @(negedge clk);
        SW2 = 1'b0;
      end
    join
    write_byte(8'h3C);
    check_frame(8'h3C, 3'b010, w);
    check("latency_after_sw2", w, 1);
    check("busy_off_end", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
